// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one INCR burst at a time from a single-port synchronous SRAM.
// Optional build macro AXI_SLAVE_WAIT_EN adds WAIT_CYCLES of delay before each rvalid/bvalid.
module axi_sram_slave #(
  parameter int MEM_AW      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [1:0]        arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [1:0]        awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [2:0]        dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge where
  // valid and ready are both high; a valid, once raised, holds its payload until then.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_LATCH = 3'd2,
    RD_RESP  = 3'd3,
    WR_DATA  = 3'd4,
    WR_RESP  = 3'd5,
    RD_WAIT  = 3'd6,
    WR_WAIT  = 3'd7
  } state_t;

  state_t            state;
  logic [3:0]        cur_id;
  logic [MEM_AW-1:0] cur_addr;
  logic [3:0]        cur_len;
  logic [3:0]        beat;
  logic              err;
  logic              last_wr;

  logic ar_grant, aw_grant, ar_oor, aw_oor;
  logic w_hs, beat_is_last, w_beat_err, w_done;

  assign dbg_state = state;

  // last_wr picks the loser of the previous arbitration when both channels request.
  assign ar_grant = resetn && (state == IDLE) && arvalid && (!awvalid || last_wr);
  assign aw_grant = resetn && (state == IDLE) && awvalid && (!arvalid || !last_wr);
  assign arready  = ar_grant;
  assign awready  = aw_grant;

  assign ar_oor       = |araddr[31:MEM_AW+2];
  assign aw_oor       = |awaddr[31:MEM_AW+2];
  assign w_hs         = wvalid && wready;
  assign beat_is_last = (beat == cur_len);
  assign w_beat_err   = err || (wlast != beat_is_last) || (wid != cur_id);
  assign w_done       = wlast || beat_is_last;

  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (state == RD_REQ && !err) begin
      ram_en   = 1'b1;
      ram_addr = cur_addr;
    end else if (state == WR_DATA && w_hs && !w_beat_err) begin
      ram_en    = 1'b1;
      ram_wen   = wstrb;
      ram_addr  = cur_addr;
      ram_wdata = wdata;
    end
  end

`ifdef AXI_SLAVE_WAIT_EN
  logic [7:0] wait_cnt;
  logic       wait_done;
  assign wait_done = (wait_cnt == 8'(WAIT_CYCLES - 1));
`endif

  logic unused;
`ifdef AXI_SLAVE_WAIT_EN
  assign unused = ^{arsize, arburst, arlock, arcache, arprot, araddr[1:0],
                    awsize, awburst, awlock, awcache, awprot, awaddr[1:0]};
`else
  assign unused = ^{arsize, arburst, arlock, arcache, arprot, araddr[1:0],
                    awsize, awburst, awlock, awcache, awprot, awaddr[1:0], 1'(WAIT_CYCLES)};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cur_id   <= 4'h0;
      cur_addr <= '0;
      cur_len  <= 4'h0;
      beat     <= 4'h0;
      err      <= 1'b0;
      last_wr  <= 1'b1;
      wready   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= 32'h0;
      rid      <= 4'h0;
      rresp    <= 2'b00;
      rlast    <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= 4'h0;
      bresp    <= 2'b00;
`ifdef AXI_SLAVE_WAIT_EN
      wait_cnt <= 8'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ar_grant) begin
            cur_id   <= arid;
            cur_addr <= araddr[MEM_AW+1:2];
            cur_len  <= arlen[3:0];
            beat     <= 4'h0;
            err      <= (|arlen[7:4]) || ar_oor;
            last_wr  <= 1'b0;
            state    <= RD_REQ;
          end else if (aw_grant) begin
            cur_id   <= awid;
            cur_addr <= awaddr[MEM_AW+1:2];
            cur_len  <= awlen[3:0];
            beat     <= 4'h0;
            err      <= (|awlen[7:4]) || aw_oor;
            last_wr  <= 1'b1;
            wready   <= 1'b1;
            state    <= WR_DATA;
          end
        end
        RD_REQ: state <= RD_LATCH;
        RD_LATCH: begin
          rdata <= err ? 32'h0 : ram_rdata;
          rid   <= cur_id;
          rresp <= err ? 2'b10 : 2'b00;
          rlast <= beat_is_last;
`ifdef AXI_SLAVE_WAIT_EN
          wait_cnt <= 8'h0;
          state    <= RD_WAIT;
`else
          rvalid <= 1'b1;
          state  <= RD_RESP;
`endif
        end
`ifdef AXI_SLAVE_WAIT_EN
        RD_WAIT: begin
          if (wait_done) begin
            rvalid <= 1'b1;
            state  <= RD_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'h1;
          end
        end
        WR_WAIT: begin
          if (wait_done) begin
            bvalid <= 1'b1;
            bid    <= cur_id;
            bresp  <= err ? 2'b10 : 2'b00;
            state  <= WR_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'h1;
          end
        end
`endif
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              rlast <= 1'b0;
              state <= IDLE;
            end else begin
              beat     <= beat + 4'h1;
              cur_addr <= cur_addr + 1'b1;
              state    <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            beat     <= beat + 4'h1;
            cur_addr <= cur_addr + 1'b1;
            err      <= w_beat_err;
            if (w_done) begin
              wready <= 1'b0;
`ifdef AXI_SLAVE_WAIT_EN
              wait_cnt <= 8'h0;
              state    <= WR_WAIT;
`else
              bvalid <= 1'b1;
              bid    <= cur_id;
              bresp  <= w_beat_err ? 2'b10 : 2'b00;
              state  <= WR_RESP;
`endif
            end
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: drivers push expected responses, a negedge monitor pops and compares.
module tb_axi_sram_slave;
  localparam int MEM_AW = 14;
`ifdef AXI_SLAVE_WAIT_EN
  localparam int RD_LAT = 5;
  localparam int B_LAT  = 3;
`else
  localparam int RD_LAT = 3;
  localparam int B_LAT  = 1;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic [3:0] arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
  logic [1:0] arburst = 2'b01, awburst = 2'b01, arlock = '0, awlock = '0;
  logic [3:0] arcache = '0, awcache = '0, wstrb = '0;
  logic arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic rready = 1'b1, bready = 1'b1;
  logic arready, awready, wready, rvalid, rlast, bvalid;
  logic [3:0] rid, bid;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  logic ram_en;
  logic [3:0] ram_wen;
  logic [MEM_AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [2:0] dbg_state;

  axi_sram_slave #(.MEM_AW(MEM_AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // clock / SRAM model
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<MEM_AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 4'b0000) ram_rdata <= mem[ram_addr];
      else for (int i = 0; i < 4; i++) if (ram_wen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_cnt = 0, err_cnt = 0;
  int hs_cyc, w_cyc, w_first_cyc, aw_cyc, rv_rise_cyc, bv_rise_cyc, ram_en_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: r = {rid, rresp, rlast, rdata}, b = {bid, bresp}
  logic [38:0] exp_r_q[$];
  logic [5:0]  exp_b_q[$];
  logic rvalid_d = 1'b0, bvalid_d = 1'b0, hold_v = 1'b0;
  logic [38:0] hold;

  always @(negedge clk) begin
    logic [38:0] e;
    logic [5:0] eb;
    if (resetn) begin
      if (rvalid && !rvalid_d) rv_rise_cyc = cyc;
      if (bvalid && !bvalid_d) bv_rise_cyc = cyc;
      if (ram_en) ram_en_cnt++;
      if (rvalid) begin
        if (hold_v) check("r_stable", {rid, rresp, rlast, rdata}, hold);
        hold_v = !rready;
        hold = {rid, rresp, rlast, rdata};
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          e = exp_r_q.pop_front();
          check("rid", rid, e[38:35]);
          check("rresp", rresp, e[34:33]);
          check("rlast", rlast, e[32]);
          check("rdata", rdata, e[31:0]);
        end
      end
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          eb = exp_b_q.pop_front();
          check("bid", bid, eb[5:2]);
          check("bresp", bresp, eb[1:0]);
        end
      end
    end else hold_v = 1'b0;
    rvalid_d = rvalid;
    bvalid_d = bvalid;
  end

  // driver tasks
  task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 100);
    if (!arready) check("ar_timeout", 0, 1);
    else hs_cyc = cyc;
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 100);
    if (!awready) check("aw_timeout", 0, 1);
    else aw_cyc = cyc;
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [3:0] id, input logic [31:0] d0, input logic [3:0] strb,
                        input int n, input int last_at);
    for (int b = 0; b < n; b++) begin
      int k = 0;
      wid = id; wdata = d0 + 32'(b); wstrb = strb; wlast = (b == last_at); wvalid = 1'b1;
      do begin @(negedge clk); k++; end while (!wready && k < 100);
      if (!wready) check("w_timeout", 0, 1);
      else begin
        w_cyc = cyc;
        if (b == 0) w_first_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_r_q.size() + exp_b_q.size()) != 0 && k < 300) begin @(negedge clk); k++; end
    check("drain", exp_r_q.size() + exp_b_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_sig(input int which, input string name);
    int k = 0;
    do begin
      @(negedge clk); k++;
    end while (!((which == 0) ? (rvalid && rready) : (which == 1) ? rvalid :
                 (which == 2) ? awready : arready) && k < 100);
    if (k >= 100) check(name, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) mem[64+i] = 32'hA0B0C000 + 32'(i);

    // reset with requests pending: nothing may be accepted
    arvalid = 1'b1; awvalid = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctl", {arready, awready, wready, rvalid, bvalid, rlast, rid, bid, rresp, bresp,
                        ram_en, ram_wen, dbg_state}, 0);
    check("reset_data", {rdata, ram_wdata}, 0);
    check("reset_addr", ram_addr, 0);
    arvalid = 1'b0; awvalid = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    // single read
    exp_r_q.push_back({4'd0, 2'b00, 1'b1, 32'hDEADBEEF});
    ar_req(4'd0, 32'h0000_0010, 8'd0);
    wait_done();
    check("rd_latency", rv_rise_cyc - hs_cyc, RD_LAT);

    // single partial write, then read back
    exp_b_q.push_back({4'd1, 2'b00});
    aw_req(4'd1, 32'h0000_0020, 8'd0);
    w_send(4'd1, 32'h12345678, 4'b0011, 1, 0);
    wait_done();
    check("wready_latency", w_first_cyc - aw_cyc, 1);
    check("b_latency", bv_rise_cyc - w_cyc, B_LAT);
    check("mem8", mem[8], 32'hFFFF5678);
    exp_r_q.push_back({4'd1, 2'b00, 1'b1, 32'hFFFF5678});
    ar_req(4'd1, 32'h0000_0020, 8'd0);
    wait_done();

    // 4-beat burst with rready low for 2 cycles on beat 1
    for (int i = 0; i < 4; i++) exp_r_q.push_back({4'd3, 2'b00, 1'(i == 3), 32'hA0B0C000 + 32'(i)});
    ar_req(4'd3, 32'h0000_0100, 8'd3);
    wait_sig(0, "beat0_timeout");
    @(posedge clk); #1 rready = 1'b0;
    wait_sig(1, "beat1_timeout");
    repeat (2) @(posedge clk);
    #1 rready = 1'b1;
    wait_done();

    // reset mid-read: no response may follow
    ar_req(4'd7, 32'h0000_0010, 8'd0);
    resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    repeat (8) @(negedge clk);
    check("abandon_valid", {rvalid, bvalid}, 0);
    check("abandon_state", dbg_state, 0);
    @(posedge clk); #1;

    // simultaneous requests: read first, then write
    exp_r_q.push_back({4'd2, 2'b00, 1'b1, 32'hDEADBEEF});
    exp_b_q.push_back({4'd3, 2'b00});
    exp_r_q.push_back({4'd4, 2'b00, 1'b1, 32'hA5A50003});
    arid = 4'd2; araddr = 32'h10; arlen = 8'd0; arvalid = 1'b1;
    awid = 4'd3; awaddr = 32'h30; awlen = 8'd0; awvalid = 1'b1;
    @(negedge clk);
    check("arb1_arready", arready, 1);
    check("arb1_awready", awready, 0);
    @(posedge clk); #1 arid = 4'd4; araddr = 32'h30;
    wait_sig(2, "arb2_timeout");
    check("arb2_arready", {arvalid, arready}, 2'b10);
    @(posedge clk); #1 awvalid = 1'b0;
    w_send(4'd3, 32'hA5A50003, 4'b1111, 1, 0);
    wait_sig(3, "arb3_timeout");
    @(posedge clk); #1 arvalid = 1'b0;
    wait_done();

    // out-of-range read: error, zero data, no SRAM access
    ram_en_cnt = 0;
    exp_r_q.push_back({4'd5, 2'b10, 1'b1, 32'h0});
    ar_req(4'd5, 32'h0001_0000, 8'd0);
    wait_done();
    check("oor_ram_en", ram_en_cnt, 0);

    // arlen upper bits set: error response
    exp_r_q.push_back({4'd6, 2'b10, 1'b1, 32'h0});
    ar_req(4'd6, 32'h0000_0010, 8'h10);
    wait_done();

    // awlen=1 but wlast on beat 0: error
    exp_b_q.push_back({4'd8, 2'b10});
    aw_req(4'd8, 32'h0000_0040, 8'd1);
    w_send(4'd8, 32'h55, 4'b1111, 1, 0);
    wait_done();

    // wid differs from awid: error
    exp_b_q.push_back({4'd9, 2'b10});
    aw_req(4'd9, 32'h0000_0044, 8'd0);
    w_send(4'd10, 32'h66, 4'b1111, 1, 0);
    wait_done();

    // 2-beat write then 2-beat read of the same words
    exp_b_q.push_back({4'd11, 2'b00});
    aw_req(4'd11, 32'h0000_0200, 8'd1);
    w_send(4'd11, 32'hC0DE0000, 4'b1111, 2, 1);
    wait_done();
    exp_r_q.push_back({4'd12, 2'b00, 1'b0, 32'hC0DE0000});
    exp_r_q.push_back({4'd12, 2'b00, 1'b1, 32'hC0DE0001});
    ar_req(4'd12, 32'h0000_0200, 8'd1);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder that services one transaction at a time against a single-port synchronous SRAM.
- Used on the simulation/FPGA side of the CPU's AXI master bridge as instruction/data memory, and as the target for bridge verification.
- Handles INCR bursts of 1-16 beats at 32 bits per beat.
- Read and write requests are arbitrated round-robin, so accesses are strictly serialised.

Parameters:
- MEM_AW, 14, SRAM word-address width (memory size = 4*2^MEM_AW bytes).
- WAIT_CYCLES, 2, extra cycles before each rvalid/bvalid; used only when AXI_SLAVE_WAIT_EN is defined.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  4/32/8/3/2/2/4/3  read address channel
- arvalid  in  1 ; arready  out  1
- rid  out  4 ; rdata  out  32 ; rresp  out  2 ; rlast  out  1 ; rvalid  out  1 ; rready  in  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/8/3/2/2/4/3  write address channel
- awvalid  in  1 ; awready  out  1
- wid  in  4 ; wdata  in  32 ; wstrb  in  4 ; wlast  in  1 ; wvalid  in  1 ; wready  out  1
- bid  out  4 ; bresp  out  2 ; bvalid  out  1 ; bready  in  1
- ram_en  out  1  SRAM access enable
- ram_wen  out  4  byte write enables (0 = read)
- ram_addr  out  MEM_AW  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid the cycle after ram_en with ram_wen=0

Behaviour:
- Reset:
  - On async assertion, all outputs go to 0 (arready, awready, wready, rvalid, bvalid, rlast, rdata, rid, bid, rresp, bresp, ram_*).
  - FSM goes to IDLE; round-robin pointer prefers read.
  - Reset mid-burst abandons the transaction; no response is issued afterwards.
- FSM states: IDLE, RD_REQ, RD_LATCH, RD_RESP, WR_DATA, WR_RESP.
- IDLE:
  - arready and awready are combinational and never high together.
  - Only arvalid: arready=1. Only awvalid: awready=1. Both: grant the channel not served last.
  - On handshake, capture id, addr[31:2] and len[3:0]; clear the beat counter.
  - arlen[7:4] or awlen[7:4] nonzero: set the error flag.
  - burst and size are ignored; the address always increments by 4 per beat and wraps modulo 2^MEM_AW.
- Range check: address out of range when addr[31:MEM_AW+2] != 0. The error flag is then set for the whole transaction, and SRAM is never accessed.
- Read path:
  - RD_REQ (1 cycle): ram_en=1 unless error; ram_wen=0; ram_addr=current word.
  - RD_LATCH (1 cycle): register ram_rdata (0 if error) into rdata.
  - RD_RESP: rvalid=1, rid=captured id, rresp=2'b10 if error else 2'b00, rlast=(beat==len).
  - rvalid, rdata, rid, rresp and rlast are held stable until rready.
  - On rvalid&rready: last beat goes to IDLE; otherwise beat++, addr+4, go to RD_REQ.
  - Latency: ar handshake in cycle 0, rvalid in cycle 3. Each subsequent beat takes 3 cycles plus rready stall.
- Write path:
  - WR_DATA: wready=1.
  - On wvalid&wready, same cycle: ram_en=1, ram_wen=wstrb, ram_addr=current word, ram_wdata=wdata (all 0 if error).
  - Error is also set if wlast != (beat==len), or if wid != captured id.
  - When the beat count reaches len+1 or wlast arrives, whichever comes first, go to WR_RESP.
  - WR_RESP: bvalid=1, bid=captured id, bresp=2'b10 if error else 2'b00, held until bready; then IDLE.
  - Latency: aw handshake cycle 0, wready cycle 1, bvalid the cycle after the final w handshake.
- Simultaneous events:
  - An arvalid during a write is not accepted until IDLE, and vice versa.
  - A read issued after a write completes always returns the written data.
- Protocol: ready outputs never depend on valid in any state except IDLE arbitration; valids never drop before handshake.

Optional Feature:
AXI_SLAVE_WAIT_EN
- Defined: a wait counter inserts WAIT_CYCLES idle cycles between RD_LATCH and RD_RESP for every beat, and before WR_RESP. Read latency becomes 3+WAIT_CYCLES. Data is held in the rdata register during the wait.
- Not defined: no wait counter is built; latencies are exactly as in Behaviour.

Test Plan:
- Reset, then single read: araddr=0x0000_0010, arid=0, arlen=0, RAM[4]=0xDEADBEEF → rvalid in cycle 3, rdata=0xDEADBEEF, rid=0, rresp=0, rlast=1.
- Single write: awaddr=0x20, awid=1, wdata=0x12345678, wstrb=4'b0011, RAM[8]=0xFFFFFFFF → RAM[8]=0xFFFF5678; bvalid the cycle after w handshake, bid=1, bresp=0. A following read of 0x20 returns 0xFFFF5678.
- 4-beat read burst at 0x100, arlen=3, with rready low for 2 cycles on beat 1 → 4 beats from RAM[64..67] in order; data held stable during stall; rlast only on beat 3.
- arvalid and awvalid asserted together in IDLE after reset → read granted first. Repeating the simultaneous request immediately after → write granted.
- Out-of-range read araddr=0x0001_0000 (MEM_AW=14) → rresp=2'b10, rdata=0, ram_en never asserted. Write with awlen=1 but wlast on beat 0 → bresp=2'b10.
- With AXI_SLAVE_WAIT_EN, WAIT_CYCLES=2 → single read rvalid in cycle 5; bvalid 3 cycles after w handshake.
